// File: rtl/key_demux_pkg.sv
// key_demux shared constants: width and saturation value of the miss counter.
package key_demux_pkg;

   localparam int MISS_CNT_W = 16;
   localparam logic [MISS_CNT_W-1:0] MISS_CNT_MAX = '1;

endpackage

// File: rtl/key_demux_slot.sv
// One-entry output register slot; a word loaded at edge N is visible from N on.
// Accepts a new word while empty or while being drained (can_load), so one word/cycle streams through.
module key_demux_slot #(
   parameter int DATA_LEN = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [DATA_LEN-1:0] ld_data,
   input  logic                ready,
   output logic                valid,
   output logic [DATA_LEN-1:0] data,
   output logic                can_load
);

   assign can_load = !valid || ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= ld_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/key_demux.sv
// Keyed demux: routes each input word to the register slot of channel in_key; out-of-range keys are dropped and flagged on miss.
// One-cycle latency; in_ready stalls only when the addressed slot is full and not draining. KEY_DEMUX_MISS_CNT_EN adds a saturating miss counter.
module key_demux
   import key_demux_pkg::*;
#(
   parameter int NR_KEY   = 2,
   parameter int KEY_LEN  = 1,
   parameter int DATA_LEN = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [KEY_LEN-1:0]           in_key,
   input  logic [DATA_LEN-1:0]          in_data,
   output logic [NR_KEY-1:0]            out_valid,
   input  logic [NR_KEY-1:0]            out_ready,
   output logic [NR_KEY*DATA_LEN-1:0]   out_data,
   output logic                         miss,
   output logic [MISS_CNT_W-1:0]        miss_cnt
);

   localparam logic [KEY_LEN:0] NR_KEY_W = (KEY_LEN+1)'(NR_KEY);

   logic              hit;
   logic              sel_can_load;
   logic              miss_acc;
   logic [NR_KEY-1:0] can_load;
   logic [NR_KEY-1:0] load;

   assign hit = ({1'b0, in_key} < NR_KEY_W);

   // Decode by comparison rather than indexing so keys beyond NR_KEY never address a slot.
   always_comb begin
      sel_can_load = 1'b0;
      load         = '0;
      for (int i = 0; i < NR_KEY; i++) begin
         if (in_key == KEY_LEN'(i)) begin
            sel_can_load = can_load[i];
            load[i]      = in_valid && can_load[i];
         end
      end
   end

   assign in_ready = hit ? sel_can_load : 1'b1;
   assign miss_acc = in_valid && !hit;

   for (genvar g = 0; g < NR_KEY; g++) begin : g_slot
      key_demux_slot #(
         .DATA_LEN (DATA_LEN)
      ) u_slot (
         .clk      (clk),
         .rst      (rst),
         .load     (load[g]),
         .ld_data  (in_data),
         .ready    (out_ready[g]),
         .valid    (out_valid[g]),
         .data     (out_data[DATA_LEN*g +: DATA_LEN]),
         .can_load (can_load[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         miss <= 1'b0;
      end else begin
         miss <= miss_acc;
      end
   end

`ifdef KEY_DEMUX_MISS_CNT_EN
   logic [MISS_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (miss_acc && (cnt_q != MISS_CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign miss_cnt = cnt_q;
`else
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_key_demux.sv
// Directed self-checking bench for key_demux with NR_KEY=4, KEY_LEN=3, DATA_LEN=8.
module tb_key_demux;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_key;
   logic [7:0]  in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;
   logic        miss;
   logic [15:0] miss_cnt;

   int total = 0;
   int bad   = 0;

   key_demux #(
      .NR_KEY   (4),
      .KEY_LEN  (3),
      .DATA_LEN (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_key    (in_key),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .miss      (miss),
      .miss_cnt  (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_cnt(input int n);
`ifdef KEY_DEMUX_MISS_CNT_EN
      return 16'(n);
`else
      return 16'h0000 & 16'(n);
`endif
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_key = 3'd1; in_data = 8'h77; out_ready = 4'b0000;
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_miss", 32'(miss), 32'h0);
      chk("rst_miss_cnt", 32'(miss_cnt), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      rst = 1'b0; in_valid = 1'b0;
      step();
      chk("rst_no_capture", 32'(out_valid), 32'h0);

      // single route plus stall on a full slot
      in_valid = 1'b1; in_key = 3'd2; in_data = 8'hA5;
      #1 chk("route_rdy", 32'(in_ready), 32'h1);
      step();
      in_key = 3'd2; in_data = 8'h5A;
      #1;
      chk("route_valid", 32'(out_valid), 32'h4);
      chk("route_data", out_data, 32'h00A5_0000);
      chk("stall_rdy", 32'(in_ready), 32'h0);
      step();
      chk("stall_hold_valid", 32'(out_valid), 32'h4);
      chk("stall_hold_data", 32'(out_data[23:16]), 32'hA5);
      chk("stall_rdy2", 32'(in_ready), 32'h0);
      out_ready = 4'b0100;
      #1 chk("unstall_rdy", 32'(in_ready), 32'h1);
      step();
      chk("unstall_valid", 32'(out_valid), 32'h4);
      chk("unstall_data", 32'(out_data[23:16]), 32'h5A);
      in_valid = 1'b0;
      step();
      chk("drain_valid", 32'(out_valid), 32'h0);
      chk("drain_keeps_data", 32'(out_data[23:16]), 32'h5A);

      // streaming across all four channels
      out_ready = 4'b1111;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_key = 3'(i); in_data = 8'h10 + 8'(i);
         #1 chk($sformatf("stream_rdy%0d", i), 32'(in_ready), 32'h1);
         step();
         chk($sformatf("stream_valid%0d", i), 32'(out_valid), 32'(4'b0001 << i));
         chk($sformatf("stream_data%0d", i), 32'(out_data[8*i +: 8]), 32'h10 + 32'(i));
      end
      in_valid = 1'b0;
      step();
      chk("stream_empty", 32'(out_valid), 32'h0);

      // same-cycle drain and load on slot 3
      out_ready = 4'b0000; in_valid = 1'b1; in_key = 3'd3; in_data = 8'h11;
      step();
      chk("dl_fill_valid", 32'(out_valid), 32'h8);
      chk("dl_fill_data", 32'(out_data[31:24]), 32'h11);
      out_ready = 4'b1000; in_data = 8'h22;
      #1 chk("dl_rdy", 32'(in_ready), 32'h1);
      step();
      chk("dl_valid", 32'(out_valid), 32'h8);
      chk("dl_data", 32'(out_data[31:24]), 32'h22);
      in_valid = 1'b0;
      step();
      chk("dl_empty", 32'(out_valid), 32'h0);

      // misses: back-to-back keys 5 and 6, then boundary key 4
      out_ready = 4'b0000; in_valid = 1'b1; in_key = 3'd5; in_data = 8'hFF;
      #1 chk("miss5_rdy", 32'(in_ready), 32'h1);
      step();
      chk("miss5_pulse", 32'(miss), 32'h1);
      in_key = 3'd6;
      #1 chk("miss6_rdy", 32'(in_ready), 32'h1);
      step();
      chk("miss6_pulse", 32'(miss), 32'h1);
      chk("miss_no_valid", 32'(out_valid), 32'h0);
      chk("miss_cnt2", 32'(miss_cnt), 32'(exp_cnt(2)));
      in_valid = 1'b0;
      step();
      chk("miss_low", 32'(miss), 32'h0);
      in_valid = 1'b1; in_key = 3'd4;
      step();
      chk("miss4_pulse", 32'(miss), 32'h1);
      chk("miss4_no_valid", 32'(out_valid), 32'h0);
      chk("miss_cnt3", 32'(miss_cnt), 32'(exp_cnt(3)));
      in_valid = 1'b0;
      step();
      chk("miss4_low", 32'(miss), 32'h0);

      // reset in mid-transfer discards buffered words
      in_valid = 1'b1; in_key = 3'd0; in_data = 8'h33;
      step();
      chk("mid_fill", 32'(out_valid), 32'h1);
      rst = 1'b1; in_key = 3'd1; in_data = 8'h44;
      step();
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_data", out_data, 32'h0);
      chk("mid_rst_cnt", 32'(miss_cnt), 32'h0);
      rst = 1'b0; in_valid = 1'b0;
      step();
      chk("mid_rst_no_capture", 32'(out_valid), 32'h0);

`ifdef KEY_DEMUX_MISS_CNT_EN
      in_valid = 1'b1; in_key = 3'd7;
      repeat (65537) step();
      chk("sat_cnt", 32'(miss_cnt), 32'hFFFF);
      step();
      step();
      chk("sat_hold", 32'(miss_cnt), 32'hFFFF);
      in_valid = 1'b0;
      step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_demux.md
# key_demux

Keyed demultiplexer: the inverse of the keyed lookup mux. It accepts one valid/ready input stream carrying a key and a data word. It routes each word into a single-entry register slot for output channel `key`. Each channel drains independently through its own valid/ready handshake. Sits between a decode/dispatch stage and per-unit consumers (e.g. ALU/LSU/CSR request ports) in the NPC datapath; unmatched keys are consumed and flagged.

## Interface
Parameters:
- `NR_KEY`, 2, number of output channels; legal keys are 0..NR_KEY-1; must satisfy NR_KEY <= 2**KEY_LEN
- `KEY_LEN`, 1, key width in bits
- `DATA_LEN`, 1, data word width in bits

Ports:
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  input word present
- `in_ready`  output  1  input word accepted this cycle when high with in_valid
- `in_key`  input  KEY_LEN  destination channel index
- `in_data`  input  DATA_LEN  payload
- `out_valid`  output  NR_KEY  bit i: slot i holds a word
- `out_ready`  input  NR_KEY  bit i: consumer i takes the word
- `out_data`  output  NR_KEY*DATA_LEN  slot i data at [DATA_LEN*(i+1)-1 -: DATA_LEN]
- `miss`  output  1  one-cycle pulse: a word with key >= NR_KEY was consumed
- `miss_cnt`  output  16  saturating count of missed words (see Configuration)

## Operation
- hit = (in_key < NR_KEY); k = in_key.
- in_ready = hit ? (!out_valid[k] || out_ready[k]) : 1. Missed words are never stalled.
- Accept = in_valid && in_ready.
- Accept with hit: slot k loads in_data and sets out_valid[k]=1 next cycle.
- Slot i clears when out_valid[i] && out_ready[i] and it is not reloaded in the same cycle.
- Simultaneous drain and load on the same slot: new word replaces old; out_valid stays 1 (full throughput, one word/cycle per channel).
- Other slots drain independently in the same cycle as an accept.
- Accept with miss: data dropped; miss=1 next cycle; miss_cnt increments, saturating at 16'hFFFF (holds, no wrap).
- out_data[i] holds its value while out_valid[i]=1 and out_ready[i]=0. Contents are don't-care while out_valid[i]=0, but the implementation keeps the last value.
- Producer rules: must hold in_key/in_data stable while in_valid && !in_ready; must not drop in_valid before acceptance.
- Consumer i rule: may assert out_ready[i] at any time, independent of out_valid[i].

## Timing
- Reset (rst=1 at clock edge): out_valid=0 all, miss=0, miss_cnt=0, out_data=0; in_ready follows its combinational rule from reset state. With any in_key, in_ready=1.
- rst asserted mid-transfer: all buffered words are discarded. A word presented in the reset cycle is not captured.
- Latency: in accept at edge N -> out_valid[k]=1 from after edge N; earliest consumer take at edge N+1.
- Combinational paths: in_key, in_valid, out_ready -> in_ready. No combinational path from input to out_valid/out_data/miss.
- miss is registered, exactly 1 cycle wide per missed word; back-to-back misses keep miss high for consecutive cycles.

## Configuration
- Macro `KEY_DEMUX_MISS_CNT_EN`.
- Defined: 16-bit saturating miss counter implemented and driven on miss_cnt.
- Undefined: no counter flops; miss_cnt tied to 16'h0000. The miss pulse and all routing behaviour are unchanged.

## Structure
- Shared package/header `key_demux_pkg`: constant MISS_CNT_W=16 and MISS_CNT_MAX.
- Sub-module `key_demux_slot`: one-entry valid/data register with load/drain handshake. Ports are load, ld_data, ready, valid, data, can_load. Instantiated NR_KEY times via generate.
- Top does key decode, in_ready select, miss pulse/counter.

## Test plan
Parameters NR_KEY=4, KEY_LEN=3, DATA_LEN=8.
- Reset: hold rst 2 cycles with in_valid=1, in_key=1 -> out_valid=4'b0000, miss=0, miss_cnt=0, out_data=0 after release.
- Single route: in_key=2, in_data=8'hA5, out_ready=0 -> next cycle out_valid=4'b0100, out_data[23:16]=8'hA5. A second word with key 2 sees in_ready=0 until out_ready[2]=1.
- Streaming: keys 0,1,2,3 on consecutive cycles, data 8'h10..8'h13, all out_ready=1 -> each channel shows its word exactly one cycle later, in_ready=1 throughout.
- Same-cycle drain+load: slot 3 full with 8'h11, out_ready[3]=1, in_key=3, in_data=8'h22 -> in_ready=1, next cycle out_valid[3]=1, data 8'h22.
- Miss: in_key=5 and 6 back-to-back -> in_ready=1 both cycles, no out_valid change, miss high 2 cycles, miss_cnt=2. Without macro, miss_cnt=0.
- Saturation (macro defined): force 65,537 misses -> miss_cnt=16'hFFFF, stays.
